// File: rtl/id_ex_decode_stage.sv
// RV32I decode plus ID/EX register: one instruction per cycle, 1-cycle latency.
// Handles load-use hazards with a single bubble, flushes, and holding while EXE stalls.
module id_ex_decode_stage #(
    parameter int ADDR_W = 32,
    parameter int ALU_W  = 4,
    parameter int BR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              registerWriteEnable,
    output logic              dataWriteEnable,
    output logic              regSelect,
    output logic              aluSrcImm,
    output logic [BR_W-1:0]   branchCtr,
    output logic [ALU_W-1:0]  aluCtr,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [ADDR_W-1:0] offset,
    output logic              illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic              rwe;
        logic              dwe;
        logic              rsel;
        logic              asi;
        logic [BR_W-1:0]   br;
        logic [ALU_W-1:0]  alu;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [ADDR_W-1:0] off;
        logic              ill;
    } idex_t;

    idex_t       q, nxt, dec;
    logic        dec_ok, use_rs1, use_rs2;
    logic [31:0] imm;
    logic [2:0]  f3;

    assign f3 = if_instr[14:12];

    function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.pc    = if_pc;
        dec.alu   = ALU_ADD;
        dec_ok    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        imm       = '0;
        case (if_instr[6:0])
            OPC_OP: begin
                dec_ok  = 1'b1;
                dec.rwe = 1'b1;
                dec.rd  = if_instr[11:7];
                dec.alu = alu_op(f3, if_instr[30]);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_ok  = 1'b1;
                dec.rwe = 1'b1;
                dec.asi = 1'b1;
                dec.rd  = if_instr[11:7];
                // bit 30 only distinguishes SRAI; ADDI has no subtract form
                dec.alu = alu_op(f3, (f3 == 3'b101) && if_instr[30]);
                use_rs1 = 1'b1;
                imm     = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_LOAD: if (f3 == 3'b010) begin
                dec_ok   = 1'b1;
                dec.rwe  = 1'b1;
                dec.rsel = 1'b1;
                dec.asi  = 1'b1;
                dec.rd   = if_instr[11:7];
                use_rs1  = 1'b1;
                imm      = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_STORE: if (f3 == 3'b010) begin
                dec_ok  = 1'b1;
                dec.dwe = 1'b1;
                dec.asi = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec_ok  = (f3 != 3'b010) && (f3 != 3'b011);
                dec.alu = ALU_SUB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
                case (f3)
                    3'b000:  dec.br = BR_W'(1);
                    3'b001:  dec.br = BR_W'(2);
                    3'b100:  dec.br = BR_W'(3);
                    3'b101:  dec.br = BR_W'(4);
                    3'b110:  dec.br = BR_W'(5);
                    3'b111:  dec.br = BR_W'(6);
                    default: dec.br = BR_W'(0);
                endcase
            end
            OPC_JAL: begin
                dec_ok  = 1'b1;
                dec.rwe = 1'b1;
                dec.br  = BR_W'(7);
                dec.rd  = if_instr[11:7];
                imm     = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            end
            OPC_LUI: begin
                dec_ok  = 1'b1;
                dec.rwe = 1'b1;
                dec.asi = 1'b1;
                dec.alu = ALU_PASSB;
                dec.rd  = if_instr[11:7];
                imm     = {if_instr[31:12], 12'b0};
            end
            default: dec_ok = 1'b0;
        endcase
        dec.rs1 = use_rs1 ? if_instr[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? if_instr[24:20] : 5'd0;
        dec.off = ADDR_W'($signed(imm));
        if (dec.rd == 5'd0) dec.rwe = 1'b0;
    end

    // Compares raw ID fields against the registered load destination only.
    assign hazard_stall = if_valid & q.valid & q.rsel & (q.rd != 5'd0) & ~flush &
                          ((use_rs1 & (if_instr[19:15] == q.rd)) |
                           (use_rs2 & (if_instr[24:20] == q.rd)));

    always_comb begin
        nxt = q;
        nxt.ill = 1'b0;
        if (flush) begin
            nxt = '0;
        end else if (ex_stall) begin
            nxt.ill = 1'b0;
        end else if (hazard_stall || !if_valid) begin
            nxt = '0;
        end else if (!dec_ok) begin
            nxt     = '0;
            nxt.ill = 1'b1;
        end else begin
            nxt = dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= nxt;
    end

    assign ex_valid            = q.valid;
    assign pc                  = q.pc;
    assign registerWriteEnable = q.rwe;
    assign dataWriteEnable     = q.dwe;
    assign regSelect           = q.rsel;
    assign aluSrcImm           = q.asi;
    assign branchCtr           = q.br;
    assign aluCtr              = q.alu;
    assign rs1                 = q.rs1;
    assign rs2                 = q.rs2;
    assign rd                  = q.rd;
    assign offset              = q.off;
    assign illegal             = q.ill;
endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench for id_ex_decode_stage: expected ID/EX contents are queued when an
// instruction is driven and compared against the register one edge later.
module tb_id_ex_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ex_stall;
    logic        flush;
    logic        hazard_stall, ex_valid, registerWriteEnable, dataWriteEnable;
    logic        regSelect, aluSrcImm, illegal;
    logic [31:0] pc, offset;
    logic [2:0]  branchCtr;
    logic [3:0]  aluCtr;
    logic [4:0]  rs1, rs2, rd;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        rwe, dwe, rsel, asi;
        logic [2:0]  br;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] off;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e, prev;

    id_ex_decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .ex_stall(ex_stall), .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .pc(pc), .registerWriteEnable(registerWriteEnable), .dataWriteEnable(dataWriteEnable),
        .regSelect(regSelect), .aluSrcImm(aluSrcImm), .branchCtr(branchCtr), .aluCtr(aluCtr),
        .rs1(rs1), .rs2(rs2), .rd(rd), .offset(offset), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t x);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(x.v));
        chk({tag, ".pc"}, pc, x.pc);
        chk({tag, ".regWE"}, 32'(registerWriteEnable), 32'(x.rwe));
        chk({tag, ".dataWE"}, 32'(dataWriteEnable), 32'(x.dwe));
        chk({tag, ".regSelect"}, 32'(regSelect), 32'(x.rsel));
        chk({tag, ".aluSrcImm"}, 32'(aluSrcImm), 32'(x.asi));
        chk({tag, ".branchCtr"}, 32'(branchCtr), 32'(x.br));
        chk({tag, ".aluCtr"}, 32'(aluCtr), 32'(x.alu));
        chk({tag, ".rs1"}, 32'(rs1), 32'(x.rs1));
        chk({tag, ".rs2"}, 32'(rs2), 32'(x.rs2));
        chk({tag, ".rd"}, 32'(rd), 32'(x.rd));
        chk({tag, ".offset"}, offset, x.off);
        chk({tag, ".illegal"}, 32'(illegal), 32'(x.ill));
    endtask

    // Drive one cycle of ID inputs, check the combinational stall, then the registered result.
    task automatic step(input string tag, input logic vld, input logic [31:0] p,
                        input logic [31:0] ins, input logic stl, input logic fl,
                        input logic hz, input exp_t x);
        exp_t got;
        @(negedge clk);
        if_valid = vld; if_pc = p; if_instr = ins; ex_stall = stl; flush = fl;
        #1;
        chk({tag, ".hazard_stall"}, 32'(hazard_stall), 32'(hz));
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_out(tag, got);
        prev = got;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", '0);
        chk("reset.hazard_stall", 32'(hazard_stall), 32'd0);
        @(negedge clk); rst = 1'b0;

        // ADD x3,x1,x2 then asynchronous reset in the middle of the next cycle
        e = '0; e.v = 1; e.pc = 32'h100; e.rwe = 1; e.rs1 = 1; e.rs2 = 2; e.rd = 3;
        step("add", 1, 32'h100, 32'h002081B3, 0, 0, 0, e);
        @(negedge clk);
        if_valid = 1'b1; if_pc = 32'h104; if_instr = 32'h002081B3;
        #1 rst = 1'b1;
        #1 chk_out("async_rst", '0);
        @(negedge clk); rst = 1'b0;

        e = '0; e.v = 1; e.pc = 32'h108; e.rwe = 1; e.asi = 1; e.rd = 5; e.off = 32'hFFFF_FFFF;
        step("addi_m1", 1, 32'h108, 32'hFFF00293, 0, 0, 0, e);

        // Load-use through rs1: one bubble, then the ADD re-decoded
        e = '0; e.v = 1; e.pc = 32'h10C; e.rwe = 1; e.rsel = 1; e.asi = 1; e.rs1 = 2; e.rd = 6; e.off = 8;
        step("lw", 1, 32'h10C, 32'h00812303, 0, 0, 0, e);
        step("lu_bubble", 1, 32'h110, 32'h001303B3, 0, 0, 1, '0);
        e = '0; e.v = 1; e.pc = 32'h110; e.rwe = 1; e.rs1 = 6; e.rs2 = 1; e.rd = 7;
        step("lu_add", 1, 32'h110, 32'h001303B3, 0, 0, 0, e);

        e = '0; e.v = 1; e.pc = 32'h114; e.dwe = 1; e.asi = 1; e.rs1 = 2; e.rs2 = 5; e.off = 12;
        step("sw", 1, 32'h114, 32'h00512623, 0, 0, 0, e);

        // Load-use through rs2 of a store
        e = '0; e.v = 1; e.pc = 32'h118; e.rwe = 1; e.rsel = 1; e.asi = 1; e.rs1 = 2; e.rd = 6; e.off = 8;
        step("lw2", 1, 32'h118, 32'h00812303, 0, 0, 0, e);
        step("lu_sw_bubble", 1, 32'h11C, 32'h00612023, 0, 0, 1, '0);
        e = '0; e.v = 1; e.pc = 32'h11C; e.dwe = 1; e.asi = 1; e.rs1 = 2; e.rs2 = 6;
        step("lu_sw", 1, 32'h11C, 32'h00612023, 0, 0, 0, e);

        // Flush suppresses the load-use stall
        e = '0; e.v = 1; e.pc = 32'h120; e.rwe = 1; e.rsel = 1; e.asi = 1; e.rs1 = 2; e.rd = 6; e.off = 8;
        step("lw3", 1, 32'h120, 32'h00812303, 0, 0, 0, e);
        step("flush_no_hz", 1, 32'h124, 32'h001303B3, 0, 1, 0, '0);

        e = '0; e.v = 1; e.pc = 32'h128; e.rwe = 1; e.alu = 1; e.rs1 = 3; e.rs2 = 4; e.rd = 8;
        step("sub", 1, 32'h128, 32'h40418433, 0, 0, 0, e);

        e = '0; e.v = 1; e.pc = 32'h12C; e.br = 2; e.alu = 1; e.rs1 = 1; e.rs2 = 2; e.off = 32'hFFFF_FFF8;
        step("bne", 1, 32'h12C, 32'hFE209CE3, 0, 0, 0, e);

        e = '0; e.v = 1; e.pc = 32'h130; e.rwe = 1; e.br = 7; e.rd = 1; e.off = 16;
        step("jal", 1, 32'h130, 32'h010000EF, 0, 0, 0, e);

        e = '0; e.v = 1; e.pc = 32'h134; e.rwe = 1; e.asi = 1; e.alu = 10; e.rd = 10; e.off = 32'h1234_5000;
        step("lui", 1, 32'h134, 32'h12345537, 0, 0, 0, e);

        e = prev; e.ill = 0;
        step("stall_hold", 1, 32'h138, 32'h002081B3, 1, 0, 0, e);
        step("flush_over_stall", 1, 32'h138, 32'hFFF00293, 1, 1, 0, '0);

        e = '0; e.ill = 1;
        step("illegal", 1, 32'h13C, 32'h00000000, 0, 0, 0, e);
        step("stall_after_ill", 1, 32'h140, 32'hFFF00293, 1, 0, 0, '0);
        step("no_valid", 0, 32'h140, 32'hFFF00293, 0, 0, 0, '0);

        e = '0; e.v = 1; e.pc = 32'h144; e.asi = 1;
        step("nop_rd0", 1, 32'h144, 32'h00000013, 0, 0, 0, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
